// File: rtl/hazard_tracker_if.sv
// Decode-side request and forwarding/stall response bundle for hazard_tracker.
// master = pipeline control (drives decode info), slave = hazard_tracker.
interface hazard_tracker_if #(
  parameter int REG_ADDR_WIDTH = 5,
  parameter int DEPTH          = 3
);
  localparam int SEL_WIDTH = $clog2(DEPTH);

  logic                      id_valid;
  logic [REG_ADDR_WIDTH-1:0] id_rs1;
  logic [REG_ADDR_WIDTH-1:0] id_rs2;
  logic                      id_use_rs1;
  logic                      id_use_rs2;
  logic                      id_early;
  logic [REG_ADDR_WIDTH-1:0] id_rd;
  logic                      id_reg_en;
  logic                      id_is_load;
  logic                      id_flush;
  logic                      adv;
  logic                      perf_clr;

  logic                      stall;
  logic [SEL_WIDTH-1:0]      fwd_a_sel;
  logic [SEL_WIDTH-1:0]      fwd_b_sel;
  logic [SEL_WIDTH-1:0]      br_a_sel;
  logic [SEL_WIDTH-1:0]      br_b_sel;
  logic [31:0]               stall_cycles;

  modport master (
    output id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_early,
           id_rd, id_reg_en, id_is_load, id_flush, adv, perf_clr,
    input  stall, fwd_a_sel, fwd_b_sel, br_a_sel, br_b_sel, stall_cycles
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_early,
           id_rd, id_reg_en, id_is_load, id_flush, adv, perf_clr,
    output stall, fwd_a_sel, fwd_b_sel, br_a_sel, br_b_sel, stall_cycles
  );
endinterface

// File: rtl/hazard_tracker.sv
// Shift-scoreboard hazard/forwarding unit: EXE and decode operand selects plus IF/ID stall.
// Define HAZARD_PERF_CNT_EN to build the saturating stall-cycle counter.
module hazard_tracker #(
  parameter int REG_ADDR_WIDTH   = 5,
  parameter int DEPTH            = 3,
  parameter int LOAD_READY_STAGE = 2
) (
  input logic            clk,
  input logic            rst,
  hazard_tracker_if.slave bus
);
  localparam int SEL_WIDTH = $clog2(DEPTH);
  typedef logic [REG_ADDR_WIDTH-1:0] addr_t;

  logic [DEPTH-1:0]     stg_valid;
  logic [DEPTH-1:0]     stg_reg_en;
  logic [DEPTH-1:0]     stg_is_load;
  addr_t                stg_rd [DEPTH];
  addr_t                exe_src [2];
  logic [1:0]           exe_use;

  addr_t                id_src [2];
  logic [1:0]           id_use;
  logic [1:0]           unresolved;
  logic [SEL_WIDTH-1:0] fwd_sel [2];
  logic [SEL_WIDTH-1:0] br_sel [2];
  logic                 stall;
  logic                 issue;

  function automatic logic data_ready(input int stage, input logic is_load);
    return is_load ? (stage >= LOAD_READY_STAGE) : (stage >= 1);
  endfunction

  assign id_src[0] = bus.id_rs1;
  assign id_src[1] = bus.id_rs2;
  assign id_use    = {bus.id_use_rs2, bus.id_use_rs1};

  // Scans run oldest to youngest so the youngest matching writer has the final say.
  always_comb begin
    unresolved = '0;
    for (int s = 0; s < 2; s++) begin
      fwd_sel[s] = '0;
      br_sel[s]  = '0;
      for (int k = DEPTH - 1; k >= 1; k--) begin
        if (stg_valid[0] && exe_use[s] && stg_valid[k] && stg_reg_en[k] &&
            stg_rd[k] == exe_src[s] && exe_src[s] != '0)
          fwd_sel[s] = SEL_WIDTH'(k);
      end
      for (int j = DEPTH - 1; j >= 0; j--) begin
        if (id_use[s] && stg_valid[j] && stg_reg_en[j] &&
            stg_rd[j] == id_src[s] && id_src[s] != '0) begin
          if (bus.id_early) begin
            unresolved[s] = !data_ready(j, stg_is_load[j]);
            br_sel[s]     = (bus.id_valid && j < DEPTH - 1) ? SEL_WIDTH'(j) : '0;
          end else begin
            unresolved[s] = (j + 1 < DEPTH) && !data_ready(j + 1, stg_is_load[j]);
            br_sel[s]     = '0;
          end
        end
      end
    end
  end

  assign stall = bus.id_valid && !bus.id_flush && (unresolved != 2'b00);
  assign issue = bus.id_valid && !bus.id_flush && !stall;

  assign bus.stall     = stall;
  assign bus.fwd_a_sel = fwd_sel[0];
  assign bus.fwd_b_sel = fwd_sel[1];
  assign bus.br_a_sel  = br_sel[0];
  assign bus.br_b_sel  = br_sel[1];

  always_ff @(posedge clk) begin
    if (rst) begin
      stg_valid   <= '0;
      stg_reg_en  <= '0;
      stg_is_load <= '0;
      for (int k = 0; k < DEPTH; k++) stg_rd[k] <= '0;
      exe_src[0]  <= '0;
      exe_src[1]  <= '0;
      exe_use     <= '0;
    end else if (bus.adv) begin
      for (int k = DEPTH - 1; k >= 1; k--) begin
        stg_valid[k]   <= stg_valid[k-1];
        stg_reg_en[k]  <= stg_reg_en[k-1];
        stg_is_load[k] <= stg_is_load[k-1];
        stg_rd[k]      <= stg_rd[k-1];
      end
      stg_valid[0]   <= issue;
      stg_reg_en[0]  <= bus.id_reg_en;
      stg_is_load[0] <= bus.id_is_load;
      stg_rd[0]      <= bus.id_rd;
      exe_src[0]     <= bus.id_rs1;
      exe_src[1]     <= bus.id_rs2;
      exe_use        <= id_use;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cnt;

  // Clear beats a coincident increment.
  always_ff @(posedge clk) begin
    if (rst || bus.perf_clr)
      stall_cnt <= '0;
    else if (stall && bus.adv && stall_cnt != 32'hFFFF_FFFF)
      stall_cnt <= stall_cnt + 32'd1;
  end

  assign bus.stall_cycles = stall_cnt;
`else
  logic unused_perf_clr;
  assign unused_perf_clr  = bus.perf_clr;
  assign bus.stall_cycles = '0;
`endif
endmodule
